// File: rtl/div_result_bcd_conv_pkg.sv
// ============================================================================
// Module : div_pkg
// Brief  : Shared types and constants for the divider-result BCD converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_result_bcd_conv_if.sv
// ============================================================================
// Module : div_result_bcd_conv_if
// Brief  : Input/output handshake bundle; DIV_ZERO_FLAG_EN adds dz_in/err_out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_result_bcd_conv_if #(
  parameter int QW = 4,
  parameter int RW = 5,
  parameter int QD = 2,
  parameter int RD = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [QW-1:0]   quot;
  logic [RW-1:0]   rem;
  logic            out_valid;
  logic            out_ready;
  logic [4*QD-1:0] quot_bcd;
  logic [4*RD-1:0] rem_bcd;
`ifdef DIV_ZERO_FLAG_EN
  logic            dz_in;
  logic            err_out;
`endif

  modport slave (
    input  in_valid, quot, rem, out_ready,
`ifdef DIV_ZERO_FLAG_EN
    input  dz_in,
    output err_out,
`endif
    output in_ready, out_valid, quot_bcd, rem_bcd
  );

  modport master (
    output in_valid, quot, rem, out_ready,
`ifdef DIV_ZERO_FLAG_EN
    output dz_in,
    input  err_out,
`endif
    input  in_ready, out_valid, quot_bcd, rem_bcd
  );

endinterface : div_result_bcd_conv_if

`default_nettype wire

// File: rtl/div_result_bcd_conv_bcd_digit_adj.sv
// ============================================================================
// Module : bcd_digit_adj
// Brief  : Double-dabble digit correction: add 3 when the digit is 5 or more.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
  import div_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADJ_THRESH) begin
      o_digit = i_digit + ADJ_ADD;
    end
  end

endmodule : bcd_digit_adj

`default_nettype wire

// File: rtl/div_result_bcd_conv.sv
// ============================================================================
// Module : div_result_bcd_conv
// Brief  : Sequential double-dabble converter of quotient/remainder to BCD.
//          Optional macro DIV_ZERO_FLAG_EN adds divide-by-zero blanking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_result_bcd_conv
  import div_pkg::*;
#(
  parameter int QW = 4,
  parameter int RW = 5,
  parameter int QD = 2,
  parameter int RD = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  div_result_bcd_conv_if.slave   bus
);

  localparam int N   = (QW > RW) ? QW : RW;
  localparam int CW  = $clog2(N + 1);
  localparam int QBW = BCD_DIGIT_W * QD;
  localparam int RBW = BCD_DIGIT_W * RD;

  if (10**QD <= (2**QW) - 1) begin : g_chk_qd
    $error("QD too small to hold the largest quotient");
  end
  if (10**RD <= (2**RW) - 1) begin : g_chk_rd
    $error("RD too small to hold the largest remainder");
  end

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_qbin;
  logic [N-1:0]   r_rbin;
  logic [QBW-1:0] r_qbcd;
  logic [RBW-1:0] r_rbcd;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [QBW-1:0] w_qadj;
  logic [RBW-1:0] w_radj;

  for (genvar gi = 0; gi < QD; gi++) begin : g_qadj
    bcd_digit_adj u_adj (
      .i_digit (r_qbcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_qadj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  for (genvar gi = 0; gi < RD; gi++) begin : g_radj
    bcd_digit_adj u_adj (
      .i_digit (r_rbcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_radj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef DIV_ZERO_FLAG_EN
  logic r_err;
  assign bus.err_out = r_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_qbin      <= '0;
      r_rbin      <= '0;
      r_qbcd      <= '0;
      r_rbcd      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_qbin     <= N'(bus.quot);
            r_rbin     <= N'(bus.rem);
            r_qbcd     <= '0;
            r_rbcd     <= '0;
            r_cnt      <= CW'(N);
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
`ifdef DIV_ZERO_FLAG_EN
            // Divide-by-zero bypasses conversion and presents blank digits.
            if (bus.dz_in) begin
              r_qbcd      <= {QD{BCD_BLANK}};
              r_rbcd      <= {RD{BCD_BLANK}};
              r_cnt       <= '0;
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
`endif
          end
        end

        SHIFT: begin
          // Adjust then shift: the binary MSB enters the BCD LSB.
          r_qbcd <= {w_qadj[QBW-2:0], r_qbin[N-1]};
          r_rbcd <= {w_radj[RBW-2:0], r_rbin[N-1]};
          r_qbin <= r_qbin << 1;
          r_rbin <= r_rbin << 1;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
`ifdef DIV_ZERO_FLAG_EN
            r_err       <= 1'b0;
`endif
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.quot_bcd  = r_qbcd;
  assign bus.rem_bcd   = r_rbcd;

endmodule : div_result_bcd_conv

`default_nettype wire

// File: tb/tb_div_result_bcd_conv.sv
// ============================================================================
// Module : tb_div_result_bcd_conv
// Brief  : Randomised self-checking bench against a decimal-arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_result_bcd_conv;

  localparam int QW = 4;
  localparam int RW = 5;
  localparam int QD = 2;
  localparam int RD = 2;
  localparam int LAT = (QW > RW) ? QW : RW;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  div_result_bcd_conv_if #(.QW(QW), .RW(RW), .QD(QD), .RD(RD)) bus ();

  div_result_bcd_conv #(.QW(QW), .RW(RW), .QD(QD), .RD(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits by repeated division, packed LSD first.
  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] res;
    int         x;
    res = '0;
    x   = v;
    for (int d = 0; d < 2; d++) begin
      res[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int q, input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.quot     = 4'(q);
        bus.rem      = 5'(r);
        tick();
        bus.in_valid = 1'b0;
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.out_valid) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.quot_bcd !== 8'h00 || bus.rem_bcd !== 8'h00) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b q=%h r=%h expected 1 0 00 00",
               bus.in_ready, bus.out_valid, bus.quot_bcd, bus.rem_bcd);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_convert(input string name, input int q, input int r);
    bit ok;
    int cyc;
    send(q, r, ok);
    wait_out(cyc);
    n_chk++;
    if (!ok || cyc !== LAT) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected %0d (accepted=%0b)", name, cyc, LAT, ok);
    end
    n_chk++;
    if (bus.quot_bcd !== to_bcd(q) || bus.rem_bcd !== to_bcd(r)) begin
      n_err++;
      $display("FAIL %s data: got %h/%h expected %h/%h", name,
               bus.quot_bcd, bus.rem_bcd, to_bcd(q), to_bcd(r));
    end
    handshake();
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s release: out_valid=%b in_ready=%b expected 0 1",
               name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    send(2, 1, ok);
    wait_out(cyc);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.quot     = 4'(9);
      bus.rem      = 5'(7);
      tick();
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.quot_bcd !== 8'h02 || bus.rem_bcd !== 8'h01) begin
        n_err++;
        $display("FAIL backpressure[%0d]: ov=%b ir=%b %h/%h expected 1 0 02/01",
                 i, bus.out_valid, bus.in_ready, bus.quot_bcd, bus.rem_bcd);
      end
    end
    bus.in_valid = 1'b0;
    handshake();
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure release: ov=%b ir=%b expected 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.quot      = 4'(5);
    bus.rem       = 5'(3);
    tick();
    bus.quot = 4'(7);
    bus.rem  = 5'(0);
    wait_out(cyc);
    n_chk++;
    if (cyc !== LAT || bus.quot_bcd !== 8'h05 || bus.rem_bcd !== 8'h03) begin
      n_err++;
      $display("FAIL b2b first: lat=%0d %h/%h expected %0d 05/03",
               cyc, bus.quot_bcd, bus.rem_bcd, LAT);
    end
    tick();
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b idle: ir=%b ov=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    n_chk++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b second accept: in_ready=%b expected 0", bus.in_ready);
    end
    wait_out(cyc);
    n_chk++;
    if (cyc !== LAT || bus.quot_bcd !== 8'h07 || bus.rem_bcd !== 8'h00) begin
      n_err++;
      $display("FAIL b2b second: lat=%0d %h/%h expected %0d 07/00",
               cyc, bus.quot_bcd, bus.rem_bcd, LAT);
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    send(11, 27, ok);
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.quot_bcd !== 8'h00 || bus.rem_bcd !== 8'h00) begin
      n_err++;
      $display("FAIL mid-shift reset: ir=%b ov=%b %h/%h expected 1 0 00/00",
               bus.in_ready, bus.out_valid, bus.quot_bcd, bus.rem_bcd);
    end
    rst = 1'b0;
    tick();
    test_convert("after_reset", 9, 4);
  endtask

  task automatic test_random();
    bit ok;
    int cyc;
    int q;
    int r;
    int d;
    for (int it = 0; it < 25; it++) begin
      q = int'($urandom_range(15, 0));
      r = int'($urandom_range(31, 0));
      d = int'($urandom_range(3, 0));
      send(q, r, ok);
      wait_out(cyc);
      repeat (d) tick();
      n_chk++;
      if (!ok || cyc !== LAT || bus.out_valid !== 1'b1 ||
          bus.quot_bcd !== to_bcd(q) || bus.rem_bcd !== to_bcd(r)) begin
        n_err++;
        $display("FAIL random q=%0d r=%0d: lat=%0d ov=%b %h/%h expected %0d 1 %h/%h",
                 q, r, cyc, bus.out_valid, bus.quot_bcd, bus.rem_bcd,
                 LAT, to_bcd(q), to_bcd(r));
      end
      handshake();
    end
  endtask

`ifdef DIV_ZERO_FLAG_EN
  task automatic test_div_zero();
    bit ok;
    int cyc;
    bus.dz_in = 1'b1;
    send(0, 10, ok);
    bus.dz_in = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.quot_bcd !== 8'hFF ||
        bus.rem_bcd !== 8'hFF || bus.err_out !== 1'b1) begin
      n_err++;
      $display("FAIL div_zero: ov=%b %h/%h err=%b expected 1 FF/FF 1",
               bus.out_valid, bus.quot_bcd, bus.rem_bcd, bus.err_out);
    end
    handshake();
    n_chk++;
    if (bus.err_out !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL div_zero clear: err=%b ov=%b expected 0 0", bus.err_out, bus.out_valid);
    end
    cyc = 0;
  endtask
`endif

  initial begin
    n_chk         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.quot      = '0;
    bus.rem       = '0;
`ifdef DIV_ZERO_FLAG_EN
    bus.dz_in     = 1'b0;
`endif
    test_reset();
    test_convert("six_by_two", 3, 0);
    test_convert("max_values", 15, 31);
    test_convert("zero", 0, 0);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
`ifdef DIV_ZERO_FLAG_EN
    test_div_zero();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_div_result_bcd_conv

`default_nettype wire
